axi_line_master: RTL

//  AXI4 initiator that moves whole cache lines between the cache/fetch side and an AXI memory slave
//  (BRAM-over-AXI now, Xilinx DRAM IP later). One request in flight: line fill = 1 read burst,

---
 rtl/axi_line_master_if.sv | 59 +++++
 rtl/axi_line_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master_if.sv
// ----------------------------------------------------------------------------
// axi_interface_if
//   AXI4 channel bundle used by axi_line_master. Single-ID, in-order traffic,
//   so no RID/BID/user/cache/prot/qos signals are carried.
//   Modports:
//     wr_mst : AW/W/B channels, initiator side
//     rd_mst : AR/R channels, initiator side
// ----------------------------------------------------------------------------
interface axi_interface_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 4
);
    // Write address
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    // Write data
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    // Write response
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    // Read address
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    // Read data
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport wr_mst (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bresp, bvalid
    );

    modport rd_mst (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_line_master.sv
// ----------------------------------------------------------------------------
// axi_line_master
//   Moves whole cache lines between the cache side and an AXI4 memory slave.
//   One request in flight: a fill is one INCR read burst of BEATS beats, a
//   writeback is one INCR write burst of BEATS beats. Every AXI output is a
//   register, so no ready feeds a valid combinationally.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     req_*        line request (valid/ready, write flag, address, wb data)
//     resp_*       one-cycle completion pulse, error flag, fill data
//     write_mst    AW/W/B initiator channels
//     read_mst     AR/R initiator channels
// ----------------------------------------------------------------------------
module axi_line_master #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int BEATS  = 8,
    parameter int AXI_ID = 0,
    parameter int ID_W   = 4,
    localparam int LINE_W = DATA_W * BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wline,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [LINE_W-1:0] resp_rline,
    axi_interface_if.wr_mst   write_mst,
    axi_interface_if.rd_mst   read_mst
);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_BURST, S_WR_RESP, S_DONE
    } state_e;

    state_e            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic              err_q;
    logic              aw_done_q, w_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wline_q;
    logic              req_ready_q, resp_valid_q, resp_err_q;
    logic [LINE_W-1:0] resp_rline_q;
    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;

    logic              accept, beat_last, r_hs, aw_hs, w_hs, b_hs;
    logic              r_beat_err, b_err, aw_done_n, w_done_n;
    logic [BEAT_W-1:0] beat_nxt;

    assign accept     = req_valid && req_ready_q;
    assign beat_last  = (beat_q == LAST);
    assign beat_nxt   = beat_q + 1'b1;
    assign r_hs       = rready_q && read_mst.rvalid;
    assign aw_hs      = awvalid_q && write_mst.awready;
    assign w_hs       = wvalid_q && write_mst.wready;
    assign b_hs       = bready_q && write_mst.bvalid;
    // A beat is bad on a non-OKAY response or when rlast disagrees with the count.
    assign r_beat_err = (read_mst.rresp != 2'b00) || (read_mst.rlast != beat_last);
    assign b_err      = (write_mst.bresp != 2'b00);
    // Burst completion includes a handshake landing in the current cycle.
    assign aw_done_n  = aw_done_q || aw_hs;
    assign w_done_n   = w_done_q || (w_hs && beat_last);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            err_q        <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rline_q <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr & ~OFF_MASK;
                        beat_q      <= '0;
                        err_q       <= 1'b0;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        if (req_write) begin
                            // AW and the first W beat go out together.
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            wlast_q   <= (BEATS == 1);
                            bready_q  <= (BEATS == 1);
                            state_q   <= S_WR_BURST;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (read_mst.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (r_hs) begin
                        resp_rline_q[beat_q*DATA_W +: DATA_W] <= read_mst.rdata;
                        beat_q <= beat_nxt;
                        err_q  <= err_q || r_beat_err;
                        if (beat_last) begin
                            rready_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= err_q || r_beat_err;
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_WR_BURST: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        if (beat_last) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            w_done_q <= 1'b1;
                        end else begin
                            beat_q  <= beat_nxt;
                            wlast_q <= (beat_nxt == LAST);
                            // bready rises with the last beat so a B arriving
                            // alongside it is taken in the same cycle.
                            bready_q <= (beat_nxt == LAST);
                        end
                    end
                    if (aw_done_n && w_done_n) begin
                        if (b_hs) begin
                            bready_q     <= 1'b0;
                            err_q        <= err_q || b_err;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= err_q || b_err;
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= S_WR_RESP;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (b_hs) begin
                        bready_q     <= 1'b0;
                        err_q        <= err_q || b_err;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q || b_err;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: pure datapath storage without reset; it is always written on
    // accept before anything reads it, so a reset would add nothing.
    always_ff @(posedge clk) begin
        if (accept && req_write) begin
            wline_q <= req_wline;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rline = resp_rline_q;

    assign read_mst.arid    = ID_W'(AXI_ID);
    assign read_mst.araddr  = addr_q;
    assign read_mst.arlen   = 8'(BEATS - 1);
    assign read_mst.arsize  = 3'($clog2(DATA_W / 8));
    assign read_mst.arburst = 2'b01;
    assign read_mst.arvalid = arvalid_q;
    assign read_mst.rready  = rready_q;

    assign write_mst.awid    = ID_W'(AXI_ID);
    assign write_mst.awaddr  = addr_q;
    assign write_mst.awlen   = 8'(BEATS - 1);
    assign write_mst.awsize  = 3'($clog2(DATA_W / 8));
    assign write_mst.awburst = 2'b01;
    assign write_mst.awvalid = awvalid_q;
    assign write_mst.wdata   = wline_q[beat_q*DATA_W +: DATA_W];
    assign write_mst.wstrb   = '1;
    assign write_mst.wlast   = wlast_q;
    assign write_mst.wvalid  = wvalid_q;
    assign write_mst.bready  = bready_q;
endmodule
